ui_config_ctrl: RTL and testbench

- Board-side receiver of the user push-button/switch protocol.
- Debounces KEY[1] (jump_stateN) and KEY[2] (jump_next_addr), samples SW[17:0], and walks the configuration sequence: slave select, R/W select, external-write select, external data entry, start/end addresses.
- Launches communication, then serves master-memory readout.
- Sits inside top between the board pins and the master/arbiter configuration ports.

---
 rtl/ui_config_ctrl_pkg.sv | 36 +++
 rtl/ui_config_ctrl_if.sv | 41 ++++
 rtl/ui_config_ctrl_button_debouncer.sv | 33 +++
 rtl/ui_config_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_ui_config_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ui_config_ctrl_pkg.sv
// Shared types for the board-side UI configuration controller.
// The state enum values double as the HEX display code.
package ui_pkg;

  typedef enum logic [3:0] {
    SLV_SEL = 4'd0,
    RW_SEL  = 4'd1,
    EXT_SEL = 4'd2,
    EXT_WR0 = 4'd3,
    EXT_WR1 = 4'd4,
    START0  = 4'd5,
    START1  = 4'd6,
    END0    = 4'd7,
    END1    = 4'd8,
    CONFIG  = 4'd9,
    READY   = 4'd10,
    COMM    = 4'd11,
    DONE    = 4'd12
  } ui_state_t;

  typedef enum logic [1:0] {
    SLAVE_NONE = 2'd0,
    SLAVE_1    = 2'd1,
    SLAVE_2    = 2'd2,
    SLAVE_3    = 2'd3
  } slave_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } operation_t;

  // Simulation-friendly default; board builds override this to 1_000_000.
  localparam int DEFAULT_DEBOUNCE = 4;

endpackage

// File: rtl/ui_config_ctrl_if.sv
// Configuration/handshake bundle between the UI controller and the master/arbiter side.
interface ui_config_ctrl_if #(
  parameter int MASTER_COUNT           = 2,
  parameter int DATA_WIDTH             = 16,
  parameter int MASTER_ADDR_WIDTH      = 12,
  parameter int MAX_MASTER_WRITE_DEPTH = 16
);

  localparam int WA = $clog2(MAX_MASTER_WRITE_DEPTH);

  logic [2*MASTER_COUNT-1:0]                 slave_sel;
  logic [MASTER_COUNT-1:0]                   master_rw;
  logic [MASTER_COUNT-1:0]                   ext_wr_sel;
  logic [MASTER_COUNT*MASTER_ADDR_WIDTH-1:0] start_addr;
  logic [MASTER_COUNT*MASTER_ADDR_WIDTH-1:0] end_addr;
  logic                                      ext_wr_valid;
  logic                                      ext_wr_master;
  logic [WA-1:0]                             ext_wr_addr;
  logic [DATA_WIDTH-1:0]                     ext_wr_data;
  logic                                      config_start;
  logic                                      config_done;
  logic                                      com_start;
  logic                                      com_done;
  logic                                      rd_valid;
  logic [MASTER_ADDR_WIDTH-1:0]              rd_addr;

  modport master (
    output slave_sel, master_rw, ext_wr_sel, start_addr, end_addr,
    output ext_wr_valid, ext_wr_master, ext_wr_addr, ext_wr_data,
    output config_start, com_start, rd_valid, rd_addr,
    input  config_done, com_done
  );

  modport slave (
    input  slave_sel, master_rw, ext_wr_sel, start_addr, end_addr,
    input  ext_wr_valid, ext_wr_master, ext_wr_addr, ext_wr_data,
    input  config_start, com_start, rd_valid, rd_addr,
    output config_done, com_done
  );

endinterface

// File: rtl/ui_config_ctrl_button_debouncer.sv
// Debounces one active-low push button into a single press pulse per press.
module button_debouncer
  import ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic rstN,
  input  logic btnN,
  output logic press_pulse
);

  localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   FULL = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] count_q;

  // The count saturates while held, so only a release can re-arm the pulse.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count_q     <= '0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= !btnN && (count_q == LAST);
      if (btnN)
        count_q <= '0;
      else if (count_q != FULL)
        count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/ui_config_ctrl.sv
// Push-button/switch configuration walker feeding the master/arbiter config ports.
// Define UI_INPUT_SYNC_EN to put 2-flop synchronizers on the buttons and switches.
module ui_config_ctrl
  import ui_pkg::*;
#(
  parameter int MASTER_COUNT           = 2,
  parameter int DATA_WIDTH             = 16,
  parameter int MASTER_ADDR_WIDTH      = 12,
  parameter int MAX_MASTER_WRITE_DEPTH = 16,
  parameter int DEBOUNCE_CYCLES        = DEFAULT_DEBOUNCE
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              jump_stateN,
  input  logic              jump_next_addr,
  input  logic [17:0]       SW,
  ui_config_ctrl_if.master  cfg,
  output logic              communication_ready,
  output logic              communication_done,
  output logic [3:0]        state_code
);

  localparam int            WA        = $clog2(MAX_MASTER_WRITE_DEPTH);
  localparam int            AW        = MASTER_ADDR_WIDTH;
  localparam logic [WA-1:0] ADDR_LAST = WA'(MAX_MASTER_WRITE_DEPTH - 1);

  logic                  state_btn_n;
  logic                  next_btn_n;
  logic [DATA_WIDTH-1:0] sw_s;
  logic                  unused_sw;

  assign unused_sw = ^SW[17:DATA_WIDTH];

`ifdef UI_INPUT_SYNC_EN
  logic [1:0]            state_sync_q;
  logic [1:0]            next_sync_q;
  logic [DATA_WIDTH-1:0] sw_meta_q;
  logic [DATA_WIDTH-1:0] sw_sync_q;

  // Buttons idle high, so their synchronizers reset to 1 to avoid a phantom press.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_sync_q <= 2'b11;
      next_sync_q  <= 2'b11;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
    end else begin
      state_sync_q <= {state_sync_q[0], jump_stateN};
      next_sync_q  <= {next_sync_q[0], jump_next_addr};
      sw_meta_q    <= SW[DATA_WIDTH-1:0];
      sw_sync_q    <= sw_meta_q;
    end
  end

  assign state_btn_n = state_sync_q[1];
  assign next_btn_n  = next_sync_q[1];
  assign sw_s        = sw_sync_q;
`else
  assign state_btn_n = jump_stateN;
  assign next_btn_n  = jump_next_addr;
  assign sw_s        = SW[DATA_WIDTH-1:0];
`endif

  logic state_ev;
  logic next_ev;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_state_db (
    .clk         (clk),
    .rstN        (rstN),
    .btnN        (state_btn_n),
    .press_pulse (state_ev)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk         (clk),
    .rstN        (rstN),
    .btnN        (next_btn_n),
    .press_pulse (next_ev)
  );

  ui_state_t state_q, state_d;
  logic      wr_req, cfg_start_req, com_start_req, rd_req;

  logic [MASTER_COUNT-1:0] ext_sel_q;
  slave_t                  slv_q   [MASTER_COUNT];
  operation_t              rw_q    [MASTER_COUNT];
  logic [AW-1:0]           start_q [MASTER_COUNT];
  logic [AW-1:0]           end_q   [MASTER_COUNT];
  logic [WA-1:0]           ext_addr_q;

  logic                  ext_wr_valid_q, ext_wr_master_q;
  logic [WA-1:0]         ext_wr_addr_q;
  logic [DATA_WIDTH-1:0] ext_wr_data_q;
  logic                  config_start_q, com_start_q, rd_valid_q;
  logic [AW-1:0]         rd_addr_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)
      state_q <= SLV_SEL;
    else
      state_q <= state_d;
  end

  // A state press always wins over a simultaneous next press.
  always_comb begin
    state_d       = state_q;
    wr_req        = 1'b0;
    cfg_start_req = 1'b0;
    com_start_req = 1'b0;
    rd_req        = 1'b0;
    unique case (state_q)
      SLV_SEL: if (state_ev) state_d = RW_SEL;
      RW_SEL:  if (state_ev) state_d = EXT_SEL;
      EXT_SEL: if (state_ev) state_d = sw_s[0] ? EXT_WR0 : (sw_s[1] ? EXT_WR1 : START0);
      EXT_WR0: begin
        wr_req = state_ev || next_ev;
        if (state_ev) state_d = ext_sel_q[1] ? EXT_WR1 : START0;
      end
      EXT_WR1: begin
        wr_req = state_ev || next_ev;
        if (state_ev) state_d = START0;
      end
      START0:  if (state_ev) state_d = START1;
      START1:  if (state_ev) state_d = END0;
      END0:    if (state_ev) state_d = END1;
      END1: begin
        if (state_ev) begin
          state_d       = CONFIG;
          cfg_start_req = 1'b1;
        end
      end
      CONFIG:  if (cfg.config_done) state_d = READY;
      READY: begin
        if (state_ev) begin
          state_d       = COMM;
          com_start_req = 1'b1;
        end
      end
      COMM:    if (cfg.com_done) state_d = DONE;
      DONE: begin
        if (state_ev)
          state_d = SLV_SEL;
        else if (next_ev)
          rd_req = 1'b1;
      end
      default: state_d = SLV_SEL;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ext_sel_q       <= '0;
      ext_addr_q      <= '0;
      ext_wr_valid_q  <= 1'b0;
      ext_wr_master_q <= 1'b0;
      ext_wr_addr_q   <= '0;
      ext_wr_data_q   <= '0;
      config_start_q  <= 1'b0;
      com_start_q     <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_addr_q       <= '0;
      for (int m = 0; m < MASTER_COUNT; m++) begin
        slv_q[m]   <= SLAVE_NONE;
        rw_q[m]    <= OP_READ;
        start_q[m] <= '0;
        end_q[m]   <= '0;
      end
    end else begin
      ext_wr_valid_q <= wr_req;
      config_start_q <= cfg_start_req;
      com_start_q    <= com_start_req;
      rd_valid_q     <= rd_req;

      // The address saturates so extra entries keep overwriting the last slot.
      if (wr_req) begin
        ext_wr_master_q <= (state_q == EXT_WR1);
        ext_wr_addr_q   <= ext_addr_q;
        ext_wr_data_q   <= sw_s;
        if (state_ev)
          ext_addr_q <= '0;
        else if (ext_addr_q != ADDR_LAST)
          ext_addr_q <= ext_addr_q + 1'b1;
      end

      if (rd_req)
        rd_addr_q <= sw_s[AW-1:0];

      if (state_ev) begin
        case (state_q)
          SLV_SEL: for (int m = 0; m < MASTER_COUNT; m++) slv_q[m] <= slave_t'(sw_s[2*m +: 2]);
          RW_SEL:  for (int m = 0; m < MASTER_COUNT; m++) rw_q[m] <= operation_t'(sw_s[m]);
          EXT_SEL: ext_sel_q <= sw_s[MASTER_COUNT-1:0];
          START0:  start_q[0] <= sw_s[AW-1:0];
          START1:  start_q[1] <= sw_s[AW-1:0];
          END0:    end_q[0]   <= sw_s[AW-1:0];
          END1:    end_q[1]   <= sw_s[AW-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cfg.slave_sel  = '0;
    cfg.master_rw  = '0;
    cfg.start_addr = '0;
    cfg.end_addr   = '0;
    for (int m = 0; m < MASTER_COUNT; m++) begin
      cfg.slave_sel[2*m +: 2]   = slv_q[m];
      cfg.master_rw[m]          = rw_q[m];
      cfg.start_addr[m*AW +: AW] = start_q[m];
      cfg.end_addr[m*AW +: AW]   = end_q[m];
    end
  end

  assign cfg.ext_wr_sel    = ext_sel_q;
  assign cfg.ext_wr_valid  = ext_wr_valid_q;
  assign cfg.ext_wr_master = ext_wr_master_q;
  assign cfg.ext_wr_addr   = ext_wr_addr_q;
  assign cfg.ext_wr_data   = ext_wr_data_q;
  assign cfg.config_start  = config_start_q;
  assign cfg.com_start     = com_start_q;
  assign cfg.rd_valid      = rd_valid_q;
  assign cfg.rd_addr       = rd_addr_q;

  assign communication_ready = (state_q == READY);
  assign communication_done  = (state_q == DONE);
  assign state_code          = state_q;

endmodule

// File: tb/tb_ui_config_ctrl.sv
// Randomized bench for ui_config_ctrl: press-level reference model plus write/pulse scoreboard.
module tb_ui_config_ctrl;
  import ui_pkg::*;

  localparam int MC    = 2;
  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int DEPTH = 16;
  localparam int DEB   = 4;

  typedef struct packed {
    logic        master;
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  logic        rstN;
  logic        jump_stateN;
  logic        jump_next_addr;
  logic [17:0] SW;
  logic        communication_ready;
  logic        communication_done;
  logic [3:0]  state_code;

  ui_config_ctrl_if #(
    .MASTER_COUNT(MC), .DATA_WIDTH(DW),
    .MASTER_ADDR_WIDTH(AW), .MAX_MASTER_WRITE_DEPTH(DEPTH)
  ) cfg_bus ();

  ui_config_ctrl #(
    .MASTER_COUNT(MC), .DATA_WIDTH(DW), .MASTER_ADDR_WIDTH(AW),
    .MAX_MASTER_WRITE_DEPTH(DEPTH), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk                 (clk),
    .rstN                (rstN),
    .jump_stateN         (jump_stateN),
    .jump_next_addr      (jump_next_addr),
    .SW                  (SW),
    .cfg                 (cfg_bus),
    .communication_ready (communication_ready),
    .communication_done  (communication_done),
    .state_code          (state_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run;
  int tests_failed;

  wr_t wr_log[$];
  wr_t wr_exp[$];
  int  cfg_pulses, com_pulses, rd_pulses;

  ui_state_t  exp_state;
  logic [3:0] exp_slv;
  logic [1:0] exp_rw;
  logic [1:0] exp_ext;
  logic [11:0] exp_start [2];
  logic [11:0] exp_end   [2];
  logic [11:0] exp_rd;
  int  exp_addr, exp_cfg, exp_com, exp_rd_cnt;

  // Scoreboard sampling on the inactive edge.
  always @(negedge clk) begin
    if (rstN) begin
      if (cfg_bus.ext_wr_valid)
        wr_log.push_back({cfg_bus.ext_wr_master, cfg_bus.ext_wr_addr, cfg_bus.ext_wr_data});
      if (cfg_bus.config_start) cfg_pulses++;
      if (cfg_bus.com_start)    com_pulses++;
      if (cfg_bus.rd_valid)     rd_pulses++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic resetModel();
    exp_state  = SLV_SEL;
    exp_slv    = '0;
    exp_rw     = '0;
    exp_ext    = '0;
    exp_start[0] = '0; exp_start[1] = '0;
    exp_end[0]   = '0; exp_end[1]   = '0;
    exp_rd     = '0;
    exp_addr   = 0;
    exp_cfg    = 0;
    exp_com    = 0;
    exp_rd_cnt = 0;
    cfg_pulses = 0;
    com_pulses = 0;
    rd_pulses  = 0;
    wr_log.delete();
    wr_exp.delete();
  endtask

  // One accepted press, described by what the user sees happen.
  task automatic modelPress(input bit s, input bit n);
    logic [17:0] sw;
    sw = SW;
    if (s) begin
      case (exp_state)
        SLV_SEL: begin exp_slv = sw[3:0]; exp_state = RW_SEL; end
        RW_SEL:  begin exp_rw = sw[1:0]; exp_state = EXT_SEL; end
        EXT_SEL: begin
          exp_ext   = sw[1:0];
          exp_state = sw[0] ? EXT_WR0 : (sw[1] ? EXT_WR1 : START0);
        end
        EXT_WR0, EXT_WR1: begin
          wr_exp.push_back({exp_state == EXT_WR1, 4'(exp_addr), sw[15:0]});
          exp_addr  = 0;
          exp_state = (exp_state == EXT_WR0 && exp_ext[1]) ? EXT_WR1 : START0;
        end
        START0: begin exp_start[0] = sw[11:0]; exp_state = START1; end
        START1: begin exp_start[1] = sw[11:0]; exp_state = END0; end
        END0:   begin exp_end[0]   = sw[11:0]; exp_state = END1; end
        END1:   begin exp_end[1]   = sw[11:0]; exp_state = CONFIG; exp_cfg++; end
        READY:  begin exp_com++; exp_state = COMM; end
        DONE:   exp_state = SLV_SEL;
        default: ;
      endcase
    end else if (n) begin
      if (exp_state == EXT_WR0 || exp_state == EXT_WR1) begin
        wr_exp.push_back({exp_state == EXT_WR1, 4'(exp_addr), sw[15:0]});
        if (exp_addr < DEPTH - 1) exp_addr++;
      end else if (exp_state == DONE) begin
        exp_rd = sw[11:0];
        exp_rd_cnt++;
      end
    end
  endtask

  task automatic applyStimulus(input bit s, input bit n, input int len);
    @(negedge clk);
    jump_stateN    = !s;
    jump_next_addr = !n;
    repeat (len) @(negedge clk);
    jump_stateN    = 1'b1;
    jump_next_addr = 1'b1;
    repeat (4) @(negedge clk);
    if (len >= DEB) modelPress(s, n);
  endtask

  task automatic randPress(input bit s, input bit n);
    SW = 18'($urandom());
    applyStimulus(s, n, $urandom_range(DEB, 12));
  endtask

  task automatic checkAll();
    checkOutput("state", 32'(state_code), 32'(exp_state));
    checkOutput("slave_sel", 32'(cfg_bus.slave_sel), 32'(exp_slv));
    checkOutput("master_rw", 32'(cfg_bus.master_rw), 32'(exp_rw));
    checkOutput("ext_wr_sel", 32'(cfg_bus.ext_wr_sel), 32'(exp_ext));
    checkOutput("start_addr", 32'(cfg_bus.start_addr), {8'h0, exp_start[1], exp_start[0]});
    checkOutput("end_addr", 32'(cfg_bus.end_addr), {8'h0, exp_end[1], exp_end[0]});
    checkOutput("comm_ready", 32'(communication_ready), 32'(exp_state == READY));
    checkOutput("comm_done", 32'(communication_done), 32'(exp_state == DONE));
    checkOutput("config_start_cycles", cfg_pulses, exp_cfg);
    checkOutput("com_start_cycles", com_pulses, exp_com);
    checkOutput("rd_valid_cycles", rd_pulses, exp_rd_cnt);
    checkOutput("rd_addr", 32'(cfg_bus.rd_addr), 32'(exp_rd));
  endtask

  task automatic checkWrites();
    checkOutput("wr_count", wr_log.size(), wr_exp.size());
    for (int i = 0; i < wr_exp.size() && i < wr_log.size(); i++)
      checkOutput($sformatf("wr%0d", i), 32'(wr_log[i]), 32'(wr_exp[i]));
    wr_log.delete();
    wr_exp.delete();
  endtask

  task automatic waitState(input ui_state_t target, input int budget);
    int n;
    n = 0;
    while (state_code !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_state", 32'(state_code), 32'(target));
  endtask

  task automatic applyReset();
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("rst_state", 32'(state_code), 32'(SLV_SEL));
    checkOutput("rst_cfg", {cfg_bus.slave_sel, cfg_bus.master_rw, cfg_bus.ext_wr_sel}, 32'h0);
    checkOutput("rst_addrs", {8'h0, cfg_bus.start_addr}, 32'h0);
    checkOutput("rst_ext_wr", {11'h0, cfg_bus.ext_wr_valid, cfg_bus.ext_wr_master,
                               cfg_bus.ext_wr_addr, cfg_bus.ext_wr_data}, 32'h0);
    checkOutput("rst_pulses", {cfg_bus.config_start, cfg_bus.com_start, cfg_bus.rd_valid,
                               communication_ready, communication_done}, 32'h0);
    checkOutput("rst_rd_addr", 32'(cfg_bus.rd_addr), 32'h0);
    resetModel();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rstN           = 1'b0;
    jump_stateN    = 1'b1;
    jump_next_addr = 1'b1;
    SW             = '0;
    cfg_bus.config_done = 1'b0;
    cfg_bus.com_done    = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    applyReset();
    checkAll();

    // Too-short press must not count.
    SW = 18'($urandom());
    applyStimulus(1'b1, 1'b0, 3);
    checkAll();

    SW = 18'($urandom());
    SW[3:0] = 4'b1001;
    applyStimulus(1'b1, 1'b0, 10);
    checkOutput("slave_sel_1001", 32'(cfg_bus.slave_sel), 32'h9);
    checkAll();

    randPress(1'b1, 1'b0);
    SW = 18'($urandom());
    SW[1:0] = 2'b11;
    applyStimulus(1'b1, 1'b0, 8);
    checkAll();

    for (int i = 0; i < 9; i++) randPress(1'b0, 1'b1);
    randPress(1'b1, 1'b0);
    checkAll();
    checkWrites();

    // Master 1 runs past the last location and keeps overwriting it.
    for (int i = 0; i < 20; i++) randPress(1'b0, 1'b1);
    randPress(1'b1, 1'b0);
    checkAll();
    checkWrites();

    SW = 18'($urandom()); SW[11:0] = 12'd0;
    applyStimulus(1'b1, 1'b0, 6);
    randPress(1'b1, 1'b0);
    randPress(1'b0, 1'b1);
    checkAll();
    checkWrites();
    SW = 18'($urandom()); SW[11:0] = 12'd10;
    applyStimulus(1'b1, 1'b0, 6);
    randPress(1'b1, 1'b0);
    checkAll();

    // Buttons do nothing while the masters configure.
    randPress(1'b1, 1'b0);
    checkAll();
    cfg_bus.config_done = 1'b1;
    exp_state = READY;
    waitState(READY, 10);
    checkAll();

    randPress(1'b1, 1'b0);
    randPress(1'b1, 1'b0);
    randPress(1'b0, 1'b1);
    checkAll();
    cfg_bus.com_done = 1'b1;
    exp_state = DONE;
    waitState(DONE, 10);
    cfg_bus.config_done = 1'b0;
    cfg_bus.com_done    = 1'b0;
    checkAll();

    SW = 18'($urandom()); SW[11:0] = 12'd5;
    applyStimulus(1'b1 == 1'b0, 1'b1, 7);
    checkOutput("rd_addr_5", 32'(cfg_bus.rd_addr), 32'd5);
    checkAll();
    randPress(1'b0, 1'b1);
    checkAll();

    randPress(1'b1, 1'b0);
    checkAll();

    // Second pass: skip straight to master 1, then press both buttons together.
    randPress(1'b1, 1'b0);
    randPress(1'b1, 1'b0);
    SW = 18'($urandom()); SW[1:0] = 2'b10;
    applyStimulus(1'b1, 1'b0, 6);
    checkAll();
    for (int i = 0; i < 3; i++) randPress(1'b0, 1'b1);
    randPress(1'b1, 1'b1);
    checkAll();
    checkWrites();

    applyReset();
    randPress(1'b1, 1'b0);
    randPress(1'b1, 1'b0);
    SW = 18'($urandom()); SW[1:0] = 2'b00;
    applyStimulus(1'b1, 1'b0, 6);
    checkAll();
    checkWrites();

    // Reset in the middle of data entry, with a press pulse already in flight.
    applyReset();
    SW = 18'($urandom()); SW[3:0] = 4'b0110;
    applyStimulus(1'b1, 1'b0, 6);
    randPress(1'b1, 1'b0);
    SW = 18'($urandom()); SW[1:0] = 2'b01;
    applyStimulus(1'b1, 1'b0, 6);
    for (int i = 0; i < 3; i++) begin
      SW = 18'($urandom()); SW[0] = 1'b1;
      applyStimulus(1'b0, 1'b1, 5);
    end
    checkAll();
    checkWrites();
    @(negedge clk);
    jump_next_addr = 1'b0;
    repeat (DEB) @(negedge clk);
    applyReset();
    jump_next_addr = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("no_write_after_reset", wr_log.size(), 0);
    checkAll();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
